delay_meter: RTL and testbench

Measures the delay, in clock cycles, between a rising edge on an asynchronous start pin and a rising edge on an asynchronous stop pin. It sits directly upstream of the output stage of the delay-measurement top level. It synchronizes both pins, runs the capture state machine, counts with a saturating counter, and presents the latched result to the consumer through a valid/ready handshake.

---
 rtl/delay_meter_pkg.sv | 14 +
 rtl/edge_sync.sv | 37 +++
 rtl/delay_meter.sv | 119 +++++++++++
 tb/tb_delay_meter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/delay_meter_pkg.sv
// Shared types and default parameters for the delay meter.
package delay_meter_pkg;

   localparam int unsigned DEF_WIDTH       = 8;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_COUNT = 2'd2,
      ST_HOLD  = 2'd3
   } state_e;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
module edge_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic pulse
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;
   logic              pulse_q, pulse_d;

   // Shift the pin through the synchronizer and flag a 0->1 transition.
   always_comb begin
      sync_d  = {sync_q[STAGES-2:0], din};
      prev_d  = sync_q[STAGES-1];
      pulse_d = sync_q[STAGES-1] & ~prev_q;
   end

   // Synchronizer, history and pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse = pulse_q;

endmodule

// File: rtl/delay_meter.sv
// Start-to-stop delay meter: synchronized pins, capture FSM, saturating
// counter and a valid/ready result register.
module delay_meter
   import delay_meter_pkg::*;
#(
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             arm,
   input  logic             start_in,
   input  logic             stop_in,
   input  logic             ready,
   output logic [WIDTH-1:0] result,
   output logic             valid,
   output logic             overflow,
   output logic             busy
);

   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic start_edge;
   logic stop_edge;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             valid_q, valid_d;
   logic             overflow_q, overflow_d;
   logic             busy_q, busy_d;

   edge_sync #(.STAGES(SYNC_STAGES)) u_start_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (start_in),
      .pulse (start_edge)
   );

   edge_sync #(.STAGES(SYNC_STAGES)) u_stop_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (stop_in),
      .pulse (stop_edge)
   );

   // Next-state, counter and output logic; everything holds while ena is low.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      result_d   = result_q;
      valid_d    = valid_q;
      overflow_d = overflow_q;

      if (ena) begin
         unique case (state_q)
            ST_IDLE: begin
               if (arm) begin
                  overflow_d = 1'b0;
                  state_d    = ST_ARMED;
               end
            end
            ST_ARMED: begin
               if (start_edge) begin
                  cnt_d   = WIDTH'(1);
                  state_d = ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (stop_edge) begin
                  result_d = cnt_q;
                  valid_d  = 1'b1;
                  state_d  = ST_HOLD;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + WIDTH'(1);
                  if (cnt_d == CNT_MAX) begin
                     overflow_d = 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (valid_q && ready) begin
                  valid_d = 1'b0;
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d == ST_ARMED) || (state_d == ST_COUNT);
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         result_q   <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
         busy_q     <= busy_d;
      end
   end

   assign result   = result_q;
   assign valid    = valid_q;
   assign overflow = overflow_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_delay_meter.sv
// Directed bench for delay_meter: inputs change and outputs are sampled on the falling edge.
module tb_delay_meter;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned SYNC  = 2;

   logic             clk;
   logic             rst;
   logic             ena;
   logic             arm;
   logic             start_in;
   logic             stop_in;
   logic             ready;
   logic [WIDTH-1:0] result;
   logic             valid;
   logic             overflow;
   logic             busy;

   int n_cmp = 0;
   int n_err = 0;

   delay_meter #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .arm      (arm),
      .start_in (start_in),
      .stop_in  (stop_in),
      .ready    (ready),
      .result   (result),
      .valid    (valid),
      .overflow (overflow),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts and reports.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick(1);
      arm = 1'b0;
   endtask

   // Raise stop, wait (bounded) for valid, check, complete the handshake, clear pins.
   task automatic finish(input string tag, input logic [31:0] exp_r, input logic [31:0] exp_o);
      bit ok;
      int i;
      ok = 1'b0;
      i  = 0;
      stop_in = 1'b1;
      while (!ok && i < 12) begin
         tick(1);
         if (valid) ok = 1'b1;
         i++;
      end
      chk({tag, "_valid_seen"}, 32'(ok), 32'd1);
      chk({tag, "_result"}, 32'(result), exp_r);
      chk({tag, "_overflow"}, 32'(overflow), exp_o);
      chk({tag, "_busy_low"}, 32'(busy), 32'd0);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      chk({tag, "_valid_drop"}, 32'(valid), 32'd0);
      chk({tag, "_result_kept"}, 32'(result), exp_r);
      chk({tag, "_overflow_kept"}, 32'(overflow), exp_o);
      start_in = 1'b0;
      stop_in  = 1'b0;
      tick(4);
   endtask

   task automatic measure(input string tag, input int d, input logic [31:0] exp_r,
                          input logic [31:0] exp_o);
      start_in = 1'b1;
      tick(d);
      finish(tag, exp_r, exp_o);
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; arm = 1'b0;
      start_in = 1'b0; stop_in = 1'b0; ready = 1'b0;

      // Reset with pins toggling, arm low.
      tick(2);
      start_in = 1'b1; tick(1);
      stop_in  = 1'b1; tick(1);
      start_in = 1'b0; tick(1);
      chk("rst_result", 32'(result), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      stop_in = 1'b0; start_in = 1'b1; tick(2);
      stop_in = 1'b1; tick(6);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_valid", 32'(valid), 32'd0);
      start_in = 1'b0; stop_in = 1'b0; tick(4);
      chk("idle_result", 32'(result), 32'd0);

      // Basic 37-cycle measurement with a stalled consumer.
      do_arm();
      chk("arm_busy", 32'(busy), 32'd1);
      start_in = 1'b1;
      tick(37);
      stop_in = 1'b1;
      tick(4);
      chk("basic_valid", 32'(valid), 32'd1);
      chk("basic_result", 32'(result), 32'd37);
      chk("basic_overflow", 32'(overflow), 32'd0);
      chk("basic_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 20; k++) begin
         tick(1);
         chk("stall_valid", 32'(valid), 32'd1);
         chk("stall_result", 32'(result), 32'd37);
      end
      ready = 1'b1; tick(1); ready = 1'b0;
      chk("basic_valid_drop", 32'(valid), 32'd0);
      chk("basic_result_kept", 32'(result), 32'd37);
      start_in = 1'b0; stop_in = 1'b0; tick(4);

      // Saturation, then re-arm clears overflow.
      do_arm();
      measure("sat", 300, 32'd255, 32'd1);
      do_arm();
      chk("rearm_overflow", 32'(overflow), 32'd0);
      chk("rearm_busy", 32'(busy), 32'd1);

      // Stop before start in ARMED is ignored.
      stop_in = 1'b1; tick(6);
      chk("early_stop_busy", 32'(busy), 32'd1);
      chk("early_stop_valid", 32'(valid), 32'd0);
      stop_in = 1'b0; tick(4);
      measure("ign_stop", 5, 32'd5, 32'd0);

      // Coincident start/stop enters COUNT; a later stop closes it.
      do_arm();
      start_in = 1'b1; stop_in = 1'b1; tick(3);
      stop_in = 1'b0; tick(6);
      chk("coinc_busy", 32'(busy), 32'd1);
      chk("coinc_valid", 32'(valid), 32'd0);
      finish("coinc", 32'd9, 32'd0);

      // Enable low for 10 of the 30 cycles.
      do_arm();
      start_in = 1'b1; tick(10);
      ena = 1'b0; tick(10);
      chk("ena_busy_hold", 32'(busy), 32'd1);
      ena = 1'b1; tick(10);
      finish("ena", 32'd20, 32'd0);

      // Reset while counting, then a clean 12-cycle measurement.
      do_arm();
      start_in = 1'b1; tick(10);
      chk("mid_busy", 32'(busy), 32'd1);
      rst = 1'b1; tick(1);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valid", 32'(valid), 32'd0);
      chk("mid_rst_result", 32'(result), 32'd0);
      rst = 1'b0; start_in = 1'b0; tick(4);
      chk("post_rst_busy", 32'(busy), 32'd0);
      do_arm();
      measure("post_rst", 12, 32'd12, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
